// File: rtl/scan_pkg.sv
// Shared types and constants for the scan-chain transaction sequencer.
package scan_pkg;

    localparam int DATA_LENG_DEF = 20;
    localparam int CNT_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_PRIME,
        ST_RUN,
        ST_CAPTURE,
        ST_FINISH
    } scan_state_e;

endpackage

// File: rtl/scan_sequencer_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/scan_sequencer.sv
// Host-side controller that sequences the scan-chain driver through reset/prime/run.
// Optional loopback comparator is enabled by defining SCAN_SEQ_LOOPBACK_EN.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DATA_LENG   = DATA_LENG_DEF,
    parameter int PRIME_CYC   = 2000000,
    parameter int RST_CYC     = 4,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic                 clki,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_LENG-1:0] wr_data,
    input  logic                 sc_done,
    input  logic [DATA_LENG-1:0] sc_rd,
    output logic                 sc_clk_enb,
    output logic                 sc_data_enb,
    output logic [DATA_LENG-1:0] sc_wr,
    output logic [DATA_LENG-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 mismatch,
    output scan_state_e          dbg_state
);

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] PRIME_LOAD   = CNT_W'(PRIME_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_LENG-1:0] sc_wr_q, sc_wr_d;
    logic [DATA_LENG-1:0] rd_data_q, rd_data_d;
    logic                 timeout_q, timeout_d;
    logic                 sc_done_sync;
    logic                 cnt_zero;

    sync2 u_done_sync (
        .clk (clki),
        .rst (rst),
        .d   (sc_done),
        .q   (sc_done_sync)
    );

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clki or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Completion is tested before the timeout so a simultaneous sc_done wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_RESET;
            ST_RESET:   if (cnt_zero) state_d = ST_PRIME;
            ST_PRIME:   if (cnt_zero) state_d = ST_RUN;
            ST_RUN: begin
                if (sc_done_sync)  state_d = ST_CAPTURE;
                else if (cnt_zero) state_d = ST_FINISH;
            end
            ST_CAPTURE: state_d = ST_FINISH;
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sc_clk_enb  = 1'b1;
        sc_data_enb = 1'b1;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FINISH);
        case (state_q)
            ST_PRIME:   sc_clk_enb = 1'b0;
            ST_RUN, ST_CAPTURE: begin
                sc_clk_enb  = 1'b0;
                sc_data_enb = 1'b0;
            end
            default: ;
        endcase
    end

    // The shared down-counter is reloaded whenever the state changes.
    always_comb begin
        cnt_d     = cnt_zero ? cnt_q : cnt_q - 1'b1;
        sc_wr_d   = sc_wr_q;
        rd_data_d = rd_data_q;
        timeout_d = timeout_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_RESET: cnt_d = RST_LOAD;
                ST_PRIME: cnt_d = PRIME_LOAD;
                ST_RUN:   cnt_d = TIMEOUT_LOAD;
                default:  cnt_d = '0;
            endcase
        end
        if (state_q == ST_IDLE && start) begin
            sc_wr_d   = wr_data;
            timeout_d = 1'b0;
        end
        if (state_q == ST_RUN && !sc_done_sync && cnt_zero) timeout_d = 1'b1;
        if (state_q == ST_CAPTURE) rd_data_d = sc_rd;
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            sc_wr_q   <= '0;
            rd_data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sc_wr_q   <= sc_wr_d;
            rd_data_q <= rd_data_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef SCAN_SEQ_LOOPBACK_EN
    // The chain returns the MSB first, so the expected read-back is sc_wr reversed.
    logic [DATA_LENG-1:0] wr_rev;
    logic                 mismatch_q, mismatch_d;

    always_comb begin
        wr_rev = '0;
        for (int i = 0; i < DATA_LENG; i++) wr_rev[i] = sc_wr_q[DATA_LENG-1-i];
    end

    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == ST_IDLE && start) mismatch_d = 1'b0;
        if (state_q == ST_CAPTURE)       mismatch_d = (sc_rd != wr_rev);
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) mismatch_q <= 1'b0;
        else     mismatch_q <= mismatch_d;
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    assign sc_wr     = sc_wr_q;
    assign rd_data   = rd_data_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed plus randomized bench for scan_sequencer with a behavioural scan driver model.
module tb_scan_sequencer;

    localparam int W        = 20;
    localparam int M        = 8;
    localparam int RUN_SCAN = (2 * W + 1) * M;
    localparam int TMO      = 2000;

    logic         clki = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] wr_data;
    logic         sc_done = 1'b0;
    logic [W-1:0] sc_rd = '0;
    logic         sc_clk_enb, sc_data_enb, busy, done, timeout, mismatch;
    logic [W-1:0] sc_wr, rd_data;
    logic [2:0]   dbg_state;

    int           tests = 0;
    int           fails = 0;
    bit           stuck = 1'b0;
    logic [W-1:0] corrupt = '0;
    int           drv_cnt = 0;

    always #5 clki = ~clki;

    scan_sequencer #(
        .DATA_LENG   (W),
        .PRIME_CYC   (8),
        .RST_CYC     (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clki        (clki),
        .rst         (rst),
        .start       (start),
        .wr_data     (wr_data),
        .sc_done     (sc_done),
        .sc_rd       (sc_rd),
        .sc_clk_enb  (sc_clk_enb),
        .sc_data_enb (sc_data_enb),
        .sc_wr       (sc_wr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .mismatch    (mismatch),
        .dbg_state   (dbg_state)
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    // Driver model: priming clears completion, running shifts 2W+1 scan periods then loops back.
    always @(negedge clki) begin
        if (rst) begin
            sc_done = 1'b0;
            drv_cnt = 0;
        end else if (!sc_clk_enb && sc_data_enb) begin
            sc_done = 1'b0;
            drv_cnt = 0;
        end else if (!sc_clk_enb && !sc_data_enb) begin
            drv_cnt++;
            if (drv_cnt == RUN_SCAN && !stuck) begin
                sc_rd   = rev(sc_wr) ^ corrupt;
                sc_done = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int run_cyc);
        int n = 0;
        run_cyc = 0;
        do begin
            @(negedge clki);
            n++;
            if (!sc_clk_enb && !sc_data_enb) run_cyc++;
        end while (!done && n < budget);
        check("done_within_budget", done, 1'b1);
    endtask

    task automatic pulse_start(input logic [W-1:0] w);
        start   = 1'b1;
        wr_data = w;
        @(negedge clki);
        start   = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clki);
            if (done) n++;
        end
    endtask

    task automatic run_txn(input logic [W-1:0] w, input logic [W-1:0] flip, input string tag);
        int           rc;
        logic         exp_mm;
        logic [W-1:0] exp_rd;
        corrupt = flip;
        stuck   = 1'b0;
        pulse_start(w);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_sc_wr"}, sc_wr, w);
        check({tag, "_timeout_clr"}, timeout, 1'b0);
        check({tag, "_mismatch_clr"}, mismatch, 1'b0);
        wait_done(5000, rc);
        exp_rd = rev(w) ^ flip;
`ifdef SCAN_SEQ_LOOPBACK_EN
        exp_mm = (flip != '0);
`else
        exp_mm = 1'b0;
`endif
        check({tag, "_rd_data"}, rd_data, exp_rd);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_mismatch"}, mismatch, exp_mm);
        @(negedge clki);
        check({tag, "_done_single"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int           rc;
        int           nd;
        logic [W-1:0] rw;
        rst     = 1'b1;
        start   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clki);
        check("rst_clk_enb", sc_clk_enb, 1'b1);
        check("rst_data_enb", sc_data_enb, 1'b1);
        check("rst_sc_wr", sc_wr, '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_mismatch", mismatch, 1'b0);
        rst = 1'b0;
        @(negedge clki);

        run_txn(20'hA5F0C, '0, "normal");
        run_txn(20'hA5F0C, 20'h00008, "corrupt");

        // Stuck driver: timeout must fire exactly TMO cycles into RUN.
        stuck = 1'b1;
        pulse_start(20'h3C3C3);
        check("stuck_mismatch_clr", mismatch, 1'b0);
        wait_done(5000, rc);
        check("stuck_run_cycles", rc, TMO);
        check("stuck_timeout", timeout, 1'b1);
        check("stuck_clk_enb", sc_clk_enb, 1'b1);
        check("stuck_data_enb", sc_data_enb, 1'b1);
        check("stuck_rd_kept", rd_data, rev(20'hA5F0C) ^ 20'h00008);
        @(negedge clki);
        check("stuck_timeout_sticky", timeout, 1'b1);
        check("stuck_done_single", done, 1'b0);

        run_txn(20'h12345, '0, "b2b");

        // Re-trigger during RUN must be ignored and not queued.
        stuck   = 1'b0;
        corrupt = '0;
        pulse_start(20'hA5F0C);
        rc = 0;
        while (!(!sc_clk_enb && !sc_data_enb) && rc < 100) begin
            @(negedge clki);
            rc++;
        end
        check("retrig_reached_run", {sc_clk_enb, sc_data_enb}, 2'b00);
        pulse_start(20'h00001);
        check("retrig_sc_wr", sc_wr, 20'hA5F0C);
        wait_done(5000, rc);
        check("retrig_rd_data", rd_data, rev(20'hA5F0C));
        count_dones(40, nd);
        check("retrig_extra_dones", nd, 0);
        check("retrig_idle", busy, 1'b0);

        // Reset asserted during PRIME.
        pulse_start(20'h0F0F0);
        rc = 0;
        while (!(!sc_clk_enb && sc_data_enb) && rc < 100) begin
            @(negedge clki);
            rc++;
        end
        check("prime_reached", {sc_clk_enb, sc_data_enb}, 2'b01);
        rst = 1'b1;
        #1;
        check("prime_rst_busy", busy, 1'b0);
        check("prime_rst_clk_enb", sc_clk_enb, 1'b1);
        check("prime_rst_data_enb", sc_data_enb, 1'b1);
        @(negedge clki);
        rst = 1'b0;
        count_dones(50, nd);
        check("prime_rst_no_done", nd, 0);
        run_txn(20'hA5F0C, '0, "after_rst");

        for (int k = 0; k < 4; k++) begin
            rw = W'($urandom_range(0, (1 << W) - 1));
            run_txn(rw, ($urandom_range(0, 1) == 1) ? W'(1 << $urandom_range(0, W - 1)) : '0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Host-side transaction controller sitting directly upstream of the scan-chain driver. It accepts a 20-bit write word and a start trigger from the host interface, and holds the word stable on the driver's parallel input. It steps the driver's clock-enable and data-enable controls through reset, prime and run phases, and waits for the driver's completion flag. It then captures the 20-bit read-back word for the host and reports done, timeout and (optionally) loopback mismatch.

## Interface
Parameters:
- `DATA_LENG`, 20: scan word width; must match the driver.
- `PRIME_CYC`, 2000000: `clki` cycles that data-enable stays high after clock-enable drops. Must be at least one full scan-clock period of the driver (its divider parameter M).
- `RST_CYC`, 4: `clki` cycles both enables are held high at transaction start.
- `TIMEOUT_CYC`, 100000000: `clki` cycles allowed in RUN before abort.

Ports:
- `clki`, in, 1: system clock (100 MHz).
- `rst`, in, 1: reset. Asynchronous, active-high.
- `start`, in, 1: one-cycle trigger from host.
- `wr_data`, in, DATA_LENG: word to scan in; sampled on accepted `start`.
- `sc_done`, in, 1: completion flag from driver. Asynchronous to `clki`.
- `sc_rd`, in, DATA_LENG: read-back word from driver. Stable while `sc_done`=1.
- `sc_clk_enb`, out, 1: driver clock enable. 1 holds the scan clock low.
- `sc_data_enb`, out, 1: driver data enable. 1 holds the driver's counter in reset.
- `sc_wr`, out, DATA_LENG: word presented to the driver.
- `rd_data`, out, DATA_LENG: captured read-back word for the host.
- `busy`, out, 1: transaction in progress.
- `done`, out, 1: one-cycle pulse at end of transaction (normal or timeout).
- `timeout`, out, 1: sticky; set on RUN timeout, cleared by next accepted `start`.
- `mismatch`, out, 1: sticky loopback compare result (see Configuration).

## Operation
- `sc_done` passes through a 2-flop synchronizer before use. `sc_rd` is sampled only once the synchronized `sc_done` is high, so it needs no synchronizer.
- FSM states: IDLE, RESET, PRIME, RUN, CAPTURE, FINISH.
- IDLE:
  - `sc_clk_enb`=1, `sc_data_enb`=1, `busy`=0.
  - `start`=1 latches `wr_data` into `sc_wr`, clears `timeout` and `mismatch`, loads the counter, and moves to RESET.
- RESET: both enables high for RST_CYC cycles, then PRIME.
- PRIME:
  - `sc_clk_enb`=0, `sc_data_enb`=1 for PRIME_CYC cycles.
  - Guarantees at least one scan-clock negedge, which resets the driver's bit counter and `sc_done`.
  - Then go to RUN.
- RUN:
  - `sc_clk_enb`=0, `sc_data_enb`=0.
  - Synchronized `sc_done`=1 moves to CAPTURE.
  - Counter reaching TIMEOUT_CYC sets `timeout` and moves to FINISH.
- CAPTURE: `rd_data` <= `sc_rd`; compare if enabled; go to FINISH.
- FINISH: `done`=1 for exactly one cycle; `sc_clk_enb`=1, `sc_data_enb`=1; return to IDLE.
- `busy`=1 in every state except IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- `sc_wr` holds its value from accept until the next accepted `start`.
- A single 32-bit down-counter serves RESET, PRIME and RUN. It is reloaded on every state entry.

## Timing
- Reset values:
  - `sc_clk_enb`=1, `sc_data_enb`=1.
  - `sc_wr`=0, `rd_data`=0.
  - `busy`=0, `done`=0, `timeout`=0, `mismatch`=0.
  - FSM in IDLE, counter=0, synchronizer flops=0.
- `rst` asserted mid-transaction forces the reset values immediately. The driver is thereby frozen, and no `done` pulse is issued.
- `start` to `busy`=1: 1 cycle.
- `done` asserts RST_CYC + PRIME_CYC + (RUN duration) + 2 cycles after accept.
  - RUN duration covers the 2-cycle synchronizer delay plus roughly 2·DATA_LENG+1 scan-clock periods.
- `done` and the updated `rd_data`/`mismatch` become visible in the same cycle.
- If `sc_done` rises in the same cycle the timeout expires, completion wins: go to CAPTURE and leave `timeout`=0.
- `start` asserted in the FINISH cycle is ignored. It is accepted only in IDLE.

## Configuration
- Macro: `SCAN_SEQ_LOOPBACK_EN`.
- Defined: CAPTURE compares `sc_rd` against the expected loopback word, which is `sc_wr` bit-reversed (the chain returns the MSB first). Any difference sets `mismatch`.
- Undefined: no comparator is built and `mismatch` is tied to 0.

## Structure
- Shared package `scan_pkg`:
  - FSM state enum.
  - `DATA_LENG` default.
  - Counter width constant (32).
- Sub-module `sync2`: generic 2-flop synchronizer with async active-high reset. It is used for `sc_done`.
- All other logic (FSM, counter, registers) is flat in `scan_sequencer`.

## Test plan
Bench settings: driver model with M=8; sequencer with PRIME_CYC=8, RST_CYC=4, TIMEOUT_CYC=2000.
- Normal transaction: `start` with `wr_data`=20'hA5F0C, model loops the chain back.
  - Expect `busy` high, then a single `done` pulse, `rd_data`=bit-reverse(20'hA5F0C), `timeout`=0, `mismatch`=0.
- Corrupted loopback: model flips bit 3 of the read-back.
  - With `SCAN_SEQ_LOOPBACK_EN`: `mismatch`=1 after `done`.
  - Without it: `mismatch`=0.
- Stuck driver: `sc_done` held 0.
  - Expect `timeout`=1 and a `done` pulse 2000 cycles after RUN entry, both enables back to 1.
- Re-trigger: `start` pulsed again mid-RUN with `wr_data`=20'h00001.
  - Expect it ignored: `sc_wr` stays 20'hA5F0C and exactly one `done` pulse.
- Reset in PRIME: assert `rst` during PRIME.
  - Expect immediate `busy`=0 and both enables=1, no `done` pulse.
  - A subsequent `start` must complete normally.
- Back-to-back: `start` accepted one cycle after `done`.
  - Expect a second full transaction, with `timeout` and `mismatch` cleared at accept.
